// File: rtl/audio_sample_packer_if.sv
// ---------------------------------------------------------------------------
// audio_sample_packer_if
//   Sample-stream handshake between an audio source and audio_sample_packer.
//
//   Signals:
//     s_valid  source -> packer  sample valid
//     s_ready  packer -> source  packer can accept a sample
//     s_data   source -> packer  signed sample, SAMPLE_W bits
//     s_chan   source -> packer  channel tag, 0 = left, 1 = right
//
//   Modports:
//     master   the sample source
//     slave    the packer
// ---------------------------------------------------------------------------
interface audio_sample_packer_if #(
    parameter int SAMPLE_W = 24
);
    logic                s_valid;
    logic                s_ready;
    logic [SAMPLE_W-1:0] s_data;
    logic                s_chan;

    modport master (
        output s_valid,
        output s_data,
        output s_chan,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_chan,
        output s_ready
    );
endinterface

// File: rtl/audio_sample_packer.sv
// ---------------------------------------------------------------------------
// audio_sample_packer
//   Takes a stream of signed mono samples tagged left/right and applies an
//   unsigned Q1.7 gain with saturation. It pairs the results into one
//   {left, right} stereo word and writes that word into the codec's I2S FIFO.
//
//   Ports:
//     clk               125 MHz clock
//     reset             synchronous reset, active-high
//     enable            gates sample acceptance
//     gain              Q1.7 gain (128 = unity), sampled on each accept
//     s_if              sample stream (slave side): s_valid/s_ready/s_data/s_chan
//     fifo_almost_full  FIFO back-pressure, checked while a word is pending
//     data_out          packed word, left in the upper half, right in the lower
//     data_wr           one-cycle FIFO write strobe
//     chan_err          one-cycle pulse on a channel-order violation
//     sat_flag          sticky saturation indicator
//     sat_clr           clears sat_flag (a same-cycle saturation wins)
//     pair_count        number of words written, wraps at 16 bits
// ---------------------------------------------------------------------------
module audio_sample_packer #(
    parameter int SAMPLE_W = 24,
    parameter int GAIN_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [GAIN_W-1:0]       gain,
    audio_sample_packer_if.slave    s_if,
    input  logic                    fifo_almost_full,
    output logic [2*SAMPLE_W-1:0]   data_out,
    output logic                    data_wr,
    output logic                    chan_err,
    output logic                    sat_flag,
    input  logic                    sat_clr,
    output logic [15:0]             pair_count
);

    // Width of the full-precision signed product of sample and {0, gain}.
    localparam int PW = SAMPLE_W + GAIN_W + 1;

    // Saturation bounds, sign-extended to the product width.
    localparam logic signed [PW-1:0] SAT_MAX =
        {{(PW-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN =
        {{(PW-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    localparam logic [1:0] WAIT_L = 2'd0;
    localparam logic [1:0] WAIT_R = 2'd1;
    localparam logic [1:0] PUSH   = 2'd2;

    logic [1:0]            state_q,      state_d;
    logic [SAMPLE_W-1:0]   left_q,       left_d;
    logic [SAMPLE_W-1:0]   right_q,      right_d;
    logic [2*SAMPLE_W-1:0] data_out_q,   data_out_d;
    logic                  data_wr_q,    data_wr_d;
    logic                  chan_err_q,   chan_err_d;
    logic                  sat_flag_q,   sat_flag_d;
    logic [15:0]           pair_count_q, pair_count_d;

    logic signed [PW-1:0]  sample_ext;
    logic signed [PW-1:0]  gain_ext;
    logic signed [PW-1:0]  product;
    logic signed [PW-1:0]  shifted;
    logic [SAMPLE_W-1:0]   scaled;
    logic                  sat_now;
    logic                  xfer;

    // Ready is also held low during reset so that nothing is accepted while
    // the state is being forced back to WAIT_L.
    assign s_if.s_ready = enable && !reset &&
                          ((state_q == WAIT_L) || (state_q == WAIT_R));
    assign xfer = s_if.s_valid && s_if.s_ready;

    // Gain path: signed multiply by a zero-extended gain, then an arithmetic
    // shift that drops the Q1.7 fraction (rounds toward minus infinity).
    always_comb begin
        sample_ext = {{(PW-SAMPLE_W){s_if.s_data[SAMPLE_W-1]}}, s_if.s_data};
        gain_ext   = {{(PW-GAIN_W){1'b0}}, gain};
        product    = sample_ext * gain_ext;
        shifted    = product >>> (GAIN_W - 1);
        sat_now    = 1'b0;
        if (shifted > SAT_MAX) begin
            scaled  = SAT_MAX[SAMPLE_W-1:0];
            sat_now = 1'b1;
        end else if (shifted < SAT_MIN) begin
            scaled  = SAT_MIN[SAMPLE_W-1:0];
            sat_now = 1'b1;
        end else begin
            scaled  = shifted[SAMPLE_W-1:0];
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default here, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d      = state_q;
        left_d       = left_q;
        right_d      = right_q;
        data_out_d   = data_out_q;
        data_wr_d    = 1'b0;
        chan_err_d   = 1'b0;
        pair_count_d = pair_count_q;
        // A saturation in this cycle overrides a simultaneous clear.
        sat_flag_d   = (sat_flag_q && !sat_clr) || (xfer && sat_now);

        case (state_q)
            WAIT_L: begin
                if (xfer) begin
                    if (!s_if.s_chan) begin
                        left_d  = scaled;
                        state_d = WAIT_R;
                    end else begin
                        chan_err_d = 1'b1;   // stray right sample is dropped
                    end
                end
            end
            WAIT_R: begin
                if (xfer) begin
                    if (s_if.s_chan) begin
                        right_d = scaled;
                        state_d = PUSH;
                    end else begin
                        left_d     = scaled; // newer left replaces the old one
                        chan_err_d = 1'b1;
                    end
                end
            end
            PUSH: begin
                if (!fifo_almost_full) begin
                    data_out_d   = {left_q, right_q};
                    data_wr_d    = 1'b1;
                    pair_count_d = pair_count_q + 16'd1;
                    state_d      = WAIT_L;
                end
            end
            default: state_d = WAIT_L;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_L;
            left_q       <= '0;
            right_q      <= '0;
            data_out_q   <= '0;
            data_wr_q    <= 1'b0;
            chan_err_q   <= 1'b0;
            sat_flag_q   <= 1'b0;
            pair_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples
            // the values from before this edge, whatever the statement order.
            state_q      <= state_d;
            left_q       <= left_d;
            right_q      <= right_d;
            data_out_q   <= data_out_d;
            data_wr_q    <= data_wr_d;
            chan_err_q   <= chan_err_d;
            sat_flag_q   <= sat_flag_d;
            pair_count_q <= pair_count_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_wr    = data_wr_q;
    assign chan_err   = chan_err_q;
    assign sat_flag   = sat_flag_q;
    assign pair_count = pair_count_q;

endmodule

// File: tb/tb_audio_sample_packer.sv
// ---------------------------------------------------------------------------
// tb_audio_sample_packer
//   Directed-vector bench for audio_sample_packer. Inputs change and outputs
//   are sampled on the falling clock edge. Each scenario task makes its own
//   comparisons against hand-computed values.
// ---------------------------------------------------------------------------
module tb_audio_sample_packer;

    localparam int SAMPLE_W = 24;
    localparam int GAIN_W   = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  enable;
    logic [GAIN_W-1:0]     gain;
    logic                  fifo_almost_full;
    logic                  sat_clr;
    logic [2*SAMPLE_W-1:0] data_out;
    logic                  data_wr;
    logic                  chan_err;
    logic                  sat_flag;
    logic [15:0]           pair_count;

    int tests_run    = 0;
    int tests_failed = 0;

    audio_sample_packer_if #(.SAMPLE_W(SAMPLE_W)) s_if ();

    audio_sample_packer #(
        .SAMPLE_W (SAMPLE_W),
        .GAIN_W   (GAIN_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .gain             (gain),
        .s_if             (s_if),
        .fifo_almost_full (fifo_almost_full),
        .data_out         (data_out),
        .data_wr          (data_wr),
        .chan_err         (chan_err),
        .sat_flag         (sat_flag),
        .sat_clr          (sat_clr),
        .pair_count       (pair_count)
    );

    always #4 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Presents one sample for one clock edge; returns chan_err as seen after it.
    task automatic send(input logic chan, input logic [SAMPLE_W-1:0] data,
                        output logic err);
        s_if.s_valid = 1'b1;
        s_if.s_chan  = chan;
        s_if.s_data  = data;
        @(posedge clk);
        @(negedge clk);
        err          = chan_err;
        s_if.s_valid = 1'b0;
    endtask

    // Waits (bounded) for a data_wr pulse; leaves the bench on that cycle.
    task automatic wait_write(output logic seen);
        int n;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (data_wr === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (s_if.s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b want 0", s_if.s_ready);
        end
        tests_run++;
        if ({data_out, data_wr, chan_err, sat_flag, pair_count} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: data_out=%h wr=%b err=%b sat=%b cnt=%h want all 0",
                     data_out, data_wr, chan_err, sat_flag, pair_count);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (s_if.s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_reset: got %b want 1", s_if.s_ready);
        end
    endtask

    task automatic test_unity;
        logic err, seen;
        gain = 8'd128;
        send(1'b0, 24'h123456, err);
        send(1'b1, 24'hFEDCBA, err);
        wait_write(seen);
        tests_run++;
        if (seen !== 1'b1 || data_out !== 48'h123456FEDCBA) begin
            tests_failed++;
            $display("FAIL unity_word: seen=%b data_out=%h want 123456fedcba", seen, data_out);
        end
        tests_run++;
        if (pair_count !== 16'd1 || sat_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL unity_count_sat: cnt=%0d sat=%b want 1/0", pair_count, sat_flag);
        end
        @(negedge clk);
        tests_run++;
        if (data_wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL unity_single_pulse: data_wr=%b want 0", data_wr);
        end
    endtask

    task automatic test_saturation;
        logic err, seen;
        gain = 8'd255;
        send(1'b0, 24'h7FFFFF, err);
        send(1'b1, 24'h800000, err);
        wait_write(seen);
        tests_run++;
        if (seen !== 1'b1 || data_out !== 48'h7FFFFF800000 || sat_flag !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_word: seen=%b data_out=%h sat=%b want 7fffff800000/1",
                     seen, data_out, sat_flag);
        end
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        tests_run++;
        if (sat_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_clear: sat=%b want 0", sat_flag);
        end
        // Clear and a new saturation in the same cycle: the flag stays set.
        sat_clr = 1'b1;
        send(1'b0, 24'h7FFFFF, err);
        sat_clr = 1'b0;
        tests_run++;
        if (sat_flag !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_set_wins: sat=%b want 1", sat_flag);
        end
        send(1'b1, 24'h000000, err);
        wait_write(seen);
        tests_run++;
        if (seen !== 1'b1 || data_out !== 48'h7FFFFF000000 || pair_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL sat_second_word: seen=%b data_out=%h cnt=%0d want 7fffff000000/3",
                     seen, data_out, pair_count);
        end
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
    endtask

    task automatic test_attenuation;
        logic err, seen;
        gain = 8'd64;
        send(1'b0, 24'h000100, err);
        send(1'b1, 24'hFFFF00, err);
        wait_write(seen);
        tests_run++;
        if (seen !== 1'b1 || data_out !== 48'h000080FFFF80 || sat_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL atten_word: seen=%b data_out=%h sat=%b want 000080ffff80/0",
                     seen, data_out, sat_flag);
        end
        // 1*64/128 -> 0, -1*64/128 -> -1 (rounds toward minus infinity).
        send(1'b0, 24'h000001, err);
        send(1'b1, 24'hFFFFFF, err);
        wait_write(seen);
        tests_run++;
        if (seen !== 1'b1 || data_out !== 48'h000000FFFFFF || pair_count !== 16'd5) begin
            tests_failed++;
            $display("FAIL atten_rounding: seen=%b data_out=%h cnt=%0d want 000000ffffff/5",
                     seen, data_out, pair_count);
        end
    endtask

    task automatic test_chan_order;
        logic err, seen;
        gain = 8'd128;
        send(1'b1, 24'h000001, err);
        tests_run++;
        if (err !== 1'b1 || s_if.s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL chan_stray_right: err=%b ready=%b want 1/1", err, s_if.s_ready);
        end
        send(1'b0, 24'h000002, err);
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL chan_first_left: err=%b want 0", err);
        end
        send(1'b0, 24'h000003, err);
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("FAIL chan_double_left: err=%b want 1", err);
        end
        send(1'b1, 24'h000004, err);
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL chan_err_one_cycle: err=%b want 0", err);
        end
        wait_write(seen);
        tests_run++;
        if (seen !== 1'b1 || data_out !== 48'h000003000004 || pair_count !== 16'd6) begin
            tests_failed++;
            $display("FAIL chan_word: seen=%b data_out=%h cnt=%0d want 000003000004/6",
                     seen, data_out, pair_count);
        end
    endtask

    task automatic test_back_pressure;
        logic err;
        int   bad;
        fifo_almost_full = 1'b1;
        send(1'b0, 24'h000010, err);
        send(1'b1, 24'h000020, err);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_if.s_ready !== 1'b0 || data_wr !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL bp_hold: %0d cycles with ready or data_wr high, want 0", bad);
        end
        fifo_almost_full = 1'b0;
        @(negedge clk);
        tests_run++;
        if (data_wr !== 1'b1 || s_if.s_ready !== 1'b1 || data_out !== 48'h000010000020) begin
            tests_failed++;
            $display("FAIL bp_release: wr=%b ready=%b data_out=%h want 1/1/000010000020",
                     data_wr, s_if.s_ready, data_out);
        end
        @(negedge clk);
        tests_run++;
        if (data_wr !== 1'b0 || pair_count !== 16'd7) begin
            tests_failed++;
            $display("FAIL bp_single_pulse: wr=%b cnt=%0d want 0/7", data_wr, pair_count);
        end
    endtask

    task automatic test_enable;
        logic err, seen;
        gain = 8'd128;
        send(1'b0, 24'h000055, err);
        enable = 1'b0;
        #1;
        tests_run++;
        if (s_if.s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL en_ready_low: ready=%b want 0", s_if.s_ready);
        end
        send(1'b1, 24'h000077, err);   // must not be accepted
        enable = 1'b1;
        send(1'b1, 24'h000066, err);
        enable = 1'b0;                 // pending push still completes
        wait_write(seen);
        tests_run++;
        if (seen !== 1'b1 || data_out !== 48'h000055000066 || pair_count !== 16'd8) begin
            tests_failed++;
            $display("FAIL en_word: seen=%b data_out=%h cnt=%0d want 000055000066/8",
                     seen, data_out, pair_count);
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid;
        logic err;
        int   bad;
        gain = 8'd255;
        send(1'b0, 24'h7FFFFF, err);   // WAIT_R with a saturated left stored
        tests_run++;
        if (sat_flag !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_pre_sat: sat=%b want 1", sat_flag);
        end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({data_out, data_wr, chan_err, sat_flag, pair_count} !== '0 || s_if.s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_wait_r: data_out=%h wr=%b sat=%b cnt=%h ready=%b want all 0",
                     data_out, data_wr, sat_flag, pair_count, s_if.s_ready);
        end
        reset = 1'b0;
        send(1'b1, 24'h000222, err);   // back in WAIT_L, so a right is an error
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_partial_dropped: err=%b want 1", err);
        end
        gain = 8'd128;
        fifo_almost_full = 1'b1;
        send(1'b0, 24'h000333, err);
        send(1'b1, 24'h000444, err);   // now held in PUSH
        reset = 1'b1;
        fifo_almost_full = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (data_wr !== 1'b0) bad++;
            @(negedge clk);
        end
        tests_run++;
        if (bad != 0 || data_out !== '0 || pair_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL rst_push_abandoned: wr_cycles=%0d data_out=%h cnt=%0d want 0/0/0",
                     bad, data_out, pair_count);
        end
    endtask

    task automatic test_wrap;
        logic err, seen;
        force dut.pair_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.pair_count_q;
        @(negedge clk);
        tests_run++;
        if (pair_count !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL wrap_preload: cnt=%h want ffff", pair_count);
        end
        send(1'b0, 24'h000001, err);
        send(1'b1, 24'h000002, err);
        wait_write(seen);
        tests_run++;
        if (seen !== 1'b1 || pair_count !== 16'h0000 || data_out !== 48'h000001000002) begin
            tests_failed++;
            $display("FAIL wrap_count: seen=%b cnt=%h data_out=%h want 1/0000/000001000002",
                     seen, pair_count, data_out);
        end
    endtask

    initial begin
        reset            = 1'b1;
        enable           = 1'b1;
        gain             = 8'd128;
        fifo_almost_full = 1'b0;
        sat_clr          = 1'b0;
        s_if.s_valid     = 1'b0;
        s_if.s_chan      = 1'b0;
        s_if.s_data      = '0;
        @(negedge clk);

        test_reset();
        test_unity();
        test_saturation();
        test_attenuation();
        test_chan_order();
        test_back_pressure();
        test_enable();
        test_reset_mid();
        test_wrap();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
